// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, LSB first.
// Computes a - b as a + ~b + 1 through one full-adder cell and a carry
// flip-flop that starts at 1. One operand bit is consumed per cycle.
// Results are published only when the last bit completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             nb;
    logic             sum_bit;
    logic             carry_out;
    logic [WIDTH-1:0] sr_shift;

    // Full-adder cell on the current LSBs with the subtrahend inverted;
    // the sum bit enters the result register from the MSB end.
    always_comb begin
        nb                 = ~b_q[0];
        sum_bit            = a_q[0] ^ nb ^ carry_q;
        carry_out          = (a_q[0] & nb) | (a_q[0] & carry_q) | (nb & carry_q);
        // Shift-then-patch keeps this valid for WIDTH=1, where no slice exists.
        sr_shift           = sr_q >> 1;
        sr_shift[WIDTH-1]  = sum_bit;
    end

    // Next-state and datapath control for IDLE -> RUN -> DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sr_d     = sr_q;
        diff_d   = diff_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sr_d    = sr_shift;
                carry_d = carry_out;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // carry_q is the carry into the MSB on this final step.
                    diff_d   = sr_shift;
                    borrow_d = ~carry_out;
                    ovf_d    = carry_q ^ carry_out;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sr_q     <= '0;
            diff_q   <= '0;
            carry_q  <= 1'b1;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sr_q     <= sr_d;
            diff_q   <= diff_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ready    = (state_q == S_IDLE);
    assign done     = (state_q == S_DONE);
    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: scoreboard of expected results pushed at
// acceptance and popped on each done pulse.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         overflow;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int unsigned  acc;
    } exp_t;

    exp_t         sb[$];
    int unsigned  done_cycs[$];
    int           checks = 0;
    int           errors = 0;
    int unsigned  cyc = 0;
    logic         armed = 1'b0;
    logic         prev_done = 1'b0;
    logic [W-1:0] last_d = '0;
    logic         last_b = 1'b0;
    logic         last_o = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: a + ~b + 1 with explicit carry; overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t       e;
        logic [W:0] full;
        full  = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        e.d   = full[W-1:0];
        e.bo  = ~full[W];
        e.ov  = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
        e.acc = 0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor at the falling edge: compare results, then predict the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            if (prev_done) check("ready_after_done", {31'b0, ready}, 32'd1);
            if (done) begin
                check("ready_in_done", {31'b0, ready}, 32'd0);
                if (sb.size() == 0) begin
                    check("done_unexpected", {31'b0, done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("diff", 32'(diff), 32'(e.d));
                    check("borrow", {31'b0, borrow}, {31'b0, e.bo});
                    check("overflow", {31'b0, overflow}, {31'b0, e.ov});
                    check("latency", cyc - e.acc, W);
                    last_d = e.d;
                    last_b = e.bo;
                    last_o = e.ov;
                    done_cycs.push_back(cyc);
                end
            end else begin
                check("hold_diff", 32'(diff), 32'(last_d));
                check("hold_borrow", {31'b0, borrow}, {31'b0, last_b});
                check("hold_overflow", {31'b0, overflow}, {31'b0, last_o});
            end
        end
        prev_done = done;
        if (rst) begin
            sb.delete();
            last_d = '0;
            last_b = 1'b0;
            last_o = 1'b0;
            armed  = 1'b1;
        end else if (armed && start && ready) begin
            e     = model(a, b);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        a     = x;
        b     = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((sb.size() != 0 || ready !== 1'b1) && n < 200) begin
            tick();
            n++;
        end
        check("timeout_pending", sb.size(), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", {31'b0, borrow}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);

        // Basic and boundary operands
        run_op(8'd5, 8'd3);
        wait_idle();
        check("diff_5_3", 32'(diff), 32'h02);
        run_op(8'h03, 8'h05);
        wait_idle();
        check("diff_3_5", 32'(diff), 32'hFE);
        check("borrow_3_5", {31'b0, borrow}, 32'd1);
        run_op(8'h80, 8'h01);
        wait_idle();
        check("diff_80_01", 32'(diff), 32'h7F);
        check("ovf_80_01", {31'b0, overflow}, 32'd1);
        run_op(8'h00, 8'h01);
        wait_idle();
        check("diff_0_1", 32'(diff), 32'hFF);
        run_op(8'h7F, 8'hFF);
        wait_idle();

        // Input changes and start pulse during RUN are ignored
        run_op(8'h10, 8'h01);
        tick();
        a     = 8'hAA;
        b     = 8'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        check("diff_10_01", 32'(diff), 32'h0F);

        // Reset in the 4th RUN cycle aborts the operation
        run_op(8'h33, 8'h11);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", {31'b0, ready}, 32'd1);
        check("abort_diff", 32'(diff), 32'd0);
        repeat (12) tick();
        run_op(8'hFF, 8'hFF);
        wait_idle();
        check("diff_ff_ff", 32'(diff), 32'h00);
        check("borrow_ff_ff", {31'b0, borrow}, 32'd0);

        // Continuous start with random operands
        done_cycs.delete();
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            tick();
        end
        start = 1'b0;
        wait_idle();
        check("stream_count", done_cycs.size() >= 19, 1);
        for (int i = 1; i < done_cycs.size(); i++)
            check("period", done_cycs[i] - done_cycs[i-1], W + 2);

        // Spaced random sweep
        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom), W'($urandom));
            repeat ($urandom_range(0, 12)) tick();
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
